// File: rtl/fft_frame_capture.sv
// Avalon-ST frame receiver: checks sop/eop framing against the declared length,
// buffers one complex frame and replays it on a valid/ready readout port.
//
// state   | meaning
// IDLE    | waiting for a sop beat; non-sop beats are dropped with an error
// CAPTURE | storing beats 1..len-1 of the current frame
// READOUT | upstream stalled, buffered frame replayed on out_*
module fft_frame_capture #(
  parameter int DATA_W     = 17,
  parameter int FFTPTS_MAX = 256,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_valid,
  output logic              sink_ready,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic [DATA_W-1:0] sink_real,
  input  logic [DATA_W-1:0] sink_imag,
  input  logic [1:0]        sink_error,
  input  logic [LEN_W-1:0]  fftpts_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

  state_t              state;
  logic [LEN_W-1:0]    len;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   rd_idx;
  logic [2*DATA_W-1:0] mem [FFTPTS_MAX];

  logic              beat;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  len_m1;
  logic [LEN_W-1:0]  cnt_ext;
  logic [LEN_W-1:0]  rd_ext;
  logic              len_bad;

  assign beat    = sink_valid && sink_ready;
  assign wr_en   = beat && (sink_sop || state == CAPTURE);
  assign wr_addr = sink_sop ? '0 : cnt;
  assign len_m1  = len - LEN_W'(1);
  assign cnt_ext = LEN_W'(cnt);
  assign rd_ext  = LEN_W'(rd_idx);
  assign len_bad = (fftpts_in == '0) || (fftpts_in > LEN_W'(FFTPTS_MAX));

  // Sample buffer has no reset; a discarded frame is simply never replayed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {sink_real, sink_imag};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      len         <= '0;
      cnt         <= '0;
      rd_idx      <= '0;
      sink_ready  <= 1'b0;
      out_valid   <= 1'b0;
      out_real    <= '0;
      out_imag    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      frame_count <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE, CAPTURE: begin
          sink_ready <= 1'b1;
          if (beat) begin
            if (sink_error != 2'b00) begin
              err_valid <= 1'b1;
              err_code  <= 3'b101;
              state     <= IDLE;
            end else if (sink_sop) begin
              len <= fftpts_in;
              cnt <= ADDR_W'(1);
              // A later error from the restarted frame overrides the abort code.
              if (state == CAPTURE) begin
                err_valid <= 1'b1;
                err_code  <= 3'b010;
              end
              if (len_bad) begin
                err_valid <= 1'b1;
                err_code  <= 3'b110;
                state     <= IDLE;
              end else if (fftpts_in == LEN_W'(1)) begin
                if (sink_eop) begin
                  state       <= READOUT;
                  sink_ready  <= 1'b0;
                  rd_idx      <= '0;
                  frame_count <= frame_count + 16'd1;
                end else begin
                  err_valid <= 1'b1;
                  err_code  <= 3'b100;
                  state     <= IDLE;
                end
              end else begin
                state <= CAPTURE;
              end
            end else if (state == IDLE) begin
              err_valid <= 1'b1;
              err_code  <= 3'b001;
            end else if (cnt_ext == len_m1) begin
              if (sink_eop) begin
                state       <= READOUT;
                sink_ready  <= 1'b0;
                rd_idx      <= '0;
                frame_count <= frame_count + 16'd1;
              end else begin
                err_valid <= 1'b1;
                err_code  <= 3'b100;
                state     <= IDLE;
              end
            end else if (sink_eop) begin
              err_valid <= 1'b1;
              err_code  <= 3'b011;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        READOUT: begin
          // Output register doubles as the one-deep read pipeline stage.
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              sink_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              out_valid              <= 1'b1;
              {out_real, out_imag}   <= mem[rd_idx];
              out_index              <= rd_idx;
              out_last               <= (rd_ext == len_m1);
              rd_idx                 <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_capture.sv
// Randomized bench for fft_frame_capture; a frame-level model (sample queues)
// predicts readout beats, error pulses, sink_ready and frame_count every cycle.
module tb_fft_frame_capture;
  localparam int DATA_W = 17;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sink_valid = 1'b0;
  logic              sink_ready;
  logic              sink_sop = 1'b0;
  logic              sink_eop = 1'b0;
  logic [DATA_W-1:0] sink_real = '0;
  logic [DATA_W-1:0] sink_imag = '0;
  logic [1:0]        sink_error = '0;
  logic [LEN_W-1:0]  fftpts_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_real;
  logic [DATA_W-1:0] out_imag;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              err_valid;
  logic [2:0]        err_code;
  logic [15:0]       frame_count;

  fft_frame_capture dut (
    .clk(clk), .reset(reset),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_error(sink_error), .fftpts_in(fftpts_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_index(out_index), .out_last(out_last),
    .err_valid(err_valid), .err_code(err_code), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    int                idx;
    bit                last;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // model state
  beat_t                 exp_q[$];
  logic [2*DATA_W-1:0]   coll_q[$];
  bit                    in_frame = 0;
  int                    frame_len = 0;
  int                    exp_fc = 0;
  bit                    busy = 0;
  bit                    exp_ready = 0;
  bit                    err_pend = 0;
  logic [2:0]            err_pend_code = '0;
  logic [2:0]            exp_code = '0;
  int                    rise_wait = -1;
  bit                    prev_reset = 0;
  bit                    prev_xfer_nonlast = 0;
  bit                    stall_snap = 0;
  logic [DATA_W-1:0]     snap_re, snap_im;
  logic [ADDR_W-1:0]     snap_idx;
  bit                    snap_last;

  // observation counters used by the literal checks
  int                    xfer_cnt = 0;
  int                    obs_err[8];
  logic [DATA_W-1:0]     last_out_real = '0;
  int                    rdy_mode = 0;
  int                    rdy_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic model_clear();
    in_frame = 0;
    coll_q.delete();
    exp_q.delete();
    busy = 0;
    exp_fc = 0;
    exp_code = '0;
    exp_ready = 0;
    rise_wait = -1;
    stall_snap = 0;
    prev_xfer_nonlast = 0;
  endtask

  task automatic set_err(input logic [2:0] code);
    err_pend = 1;
    err_pend_code = code;
  endtask

  task automatic complete_frame();
    for (int i = 0; i < coll_q.size(); i++) begin
      beat_t b;
      b.re = coll_q[i][2*DATA_W-1:DATA_W];
      b.im = coll_q[i][DATA_W-1:0];
      b.idx = i;
      b.last = (i == coll_q.size() - 1);
      exp_q.push_back(b);
    end
    coll_q.delete();
    exp_fc++;
    busy = 1;
    rise_wait = 0;
  endtask

  // Frame rules applied to one accepted beat.
  task automatic model_accept(output bit done);
    logic [2*DATA_W-1:0] s;
    s = {sink_real, sink_imag};
    done = 0;
    if (sink_error != 2'b00) begin
      set_err(3'b101);
      in_frame = 0;
      coll_q.delete();
    end else if (sink_sop) begin
      if (in_frame) set_err(3'b010);
      frame_len = int'(fftpts_in);
      coll_q.delete();
      coll_q.push_back(s);
      in_frame = 0;
      if (frame_len == 0 || frame_len > 256) set_err(3'b110);
      else if (frame_len == 1) begin
        if (sink_eop) begin complete_frame(); done = 1; end
        else set_err(3'b100);
      end else in_frame = 1;
    end else if (!in_frame) begin
      set_err(3'b001);
    end else begin
      coll_q.push_back(s);
      if (coll_q.size() == frame_len) begin
        in_frame = 0;
        if (sink_eop) begin complete_frame(); done = 1; end
        else begin set_err(3'b100); coll_q.delete(); end
      end else if (sink_eop) begin
        set_err(3'b011);
        in_frame = 0;
        coll_q.delete();
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    bit done_frame;
    bit xfer;
    bit model_last;
    done_frame = 0;
    xfer = 0;
    model_last = 0;
    if (prev_reset) begin
      check("rst_sink_ready", sink_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_real", out_real, 0);
      check("rst_out_imag", out_imag, 0);
      check("rst_out_index", out_index, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err_valid", err_valid, 0);
      check("rst_err_code", err_code, 0);
      check("rst_frame_count", frame_count, 0);
    end else begin
      check("sink_ready", sink_ready, exp_ready);
      check("err_valid", err_valid, err_pend);
      if (err_valid) obs_err[err_code]++;
      if (err_pend) exp_code = err_pend_code;
      check("err_code", err_code, exp_code);
      check("frame_count", frame_count, 64'(16'(exp_fc)));
      if (rise_wait >= 0) begin
        rise_wait++;
        if (out_valid || rise_wait >= 2) begin
          check("out_valid_rise", out_valid, 1);
          rise_wait = -1;
        end
      end
      if (stall_snap) begin
        check("stall_valid", out_valid, 1);
        check("stall_real", out_real, snap_re);
        check("stall_imag", out_imag, snap_im);
        check("stall_index", out_index, snap_idx);
        check("stall_last", out_last, snap_last);
      end
      if (prev_xfer_nonlast && out_ready) check("no_bubble", out_valid, 1);
      stall_snap = out_valid && !out_ready;
      snap_re = out_real; snap_im = out_imag; snap_idx = out_index; snap_last = out_last;
      if (out_valid && out_ready) begin
        xfer = 1;
        xfer_cnt++;
        last_out_real = out_real;
        if (exp_q.size() == 0) fail_now("unexpected_out_beat");
        else begin
          e = exp_q.pop_front();
          model_last = e.last;
          check("out_real", out_real, e.re);
          check("out_imag", out_imag, e.im);
          check("out_index", out_index, 64'(e.idx));
          check("out_last", out_last, e.last);
        end
      end
      prev_xfer_nonlast = xfer && !model_last;
    end
    err_pend = 0;
    if (reset) begin
      model_clear();
      prev_reset = 1;
    end else begin
      prev_reset = 0;
      if (model_last) busy = 0;
      if (sink_valid && sink_ready) model_accept(done_frame);
      exp_ready = done_frame ? 1'b0 : !busy;
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_cyc++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input bit sop, input bit eop, input logic [DATA_W-1:0] re,
                           input logic [DATA_W-1:0] im, input logic [1:0] er, input logic [LEN_W-1:0] len);
    bit ok;
    ok = 0;
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    sink_real = re; sink_imag = im; sink_error = er; fftpts_in = len;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sink_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("sink_ready_timeout");
    @(posedge clk);
    #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
  endtask

  task automatic send_frame(input int len, input int nbeats, input int eop_at, input int err_at,
                            input bit ramp, input bit gaps);
    logic [DATA_W-1:0] re, im;
    logic [1:0] er;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      re = ramp ? DATA_W'(b) : DATA_W'($urandom);
      im = ramp ? DATA_W'(-b) : DATA_W'($urandom);
      er = (b == err_at) ? 2'($urandom_range(1, 3)) : 2'b00;
      send_beat(b == 0, b == eop_at, re, im, er, LEN_W'(len));
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (!busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sink_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    int x0, e0;
    bit ok;
    for (int i = 0; i < 8; i++) obs_err[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 256-pt ramp, out_ready held high
    rdy_mode = 0;
    x0 = xfer_cnt;
    send_frame(256, 256, 255, -1, 1, 0);
    wait_drain();
    check("t1_frame_count", frame_count, 1);
    check("t1_beats", 64'(xfer_cnt - x0), 256);

    // same frame with stall pattern 1,0,0,1
    rdy_mode = 1;
    x0 = xfer_cnt;
    send_frame(256, 256, 255, -1, 1, 0);
    wait_drain();
    check("t2_frame_count", frame_count, 2);
    check("t2_beats", 64'(xfer_cnt - x0), 256);

    // early eop at beat 100, then a clean frame
    do_reset();
    rdy_mode = 2;
    e0 = obs_err[3];
    send_frame(256, 100, 99, -1, 0, 1);
    send_frame(256, 256, 255, -1, 0, 1);
    wait_drain();
    check("t3_err011", 64'(obs_err[3] - e0), 1);
    check("t3_frame_count", frame_count, 1);

    // sop re-asserted at beat 50
    do_reset();
    e0 = obs_err[2];
    send_frame(256, 50, -1, -1, 0, 0);
    send_frame(256, 256, 255, -1, 0, 0);
    wait_drain();
    check("t4_err010", 64'(obs_err[2] - e0), 1);
    check("t4_frame_count", frame_count, 1);

    // three beats without sop, then a 1-point frame of -65536
    do_reset();
    e0 = obs_err[1];
    for (int i = 0; i < 3; i++) send_beat(0, 0, DATA_W'($urandom), DATA_W'($urandom), 2'b00, 9'd256);
    wait_drain();
    check("t5_err001", 64'(obs_err[1] - e0), 3);
    check("t5_frame_count0", frame_count, 0);
    x0 = xfer_cnt;
    send_beat(1, 1, 17'h10000, 17'h00005, 2'b00, 9'd1);
    wait_drain();
    check("t5_beats", 64'(xfer_cnt - x0), 1);
    check("t5_out_real", last_out_real, 17'h10000);
    check("t5_frame_count1", frame_count, 1);

    // reset in the middle of readout
    rdy_mode = 0;
    x0 = xfer_cnt;
    send_frame(256, 256, 255, -1, 1, 0);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (xfer_cnt - x0 >= 10) begin ok = 1; break; end
    end
    if (!ok) fail_now("t6_readout_timeout");
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_frame_count", frame_count, 0);
    rdy_mode = 2;
    send_frame(256, 256, 255, -1, 0, 1);
    wait_drain();
    check("t6_frame_count_after", frame_count, 1);

    // random mix of clean and faulty frames
    for (int k = 0; k < 14; k++) begin
      int kind, len;
      kind = $urandom_range(0, 5);
      len = ($urandom_range(0, 4) == 0) ? 256 : $urandom_range(2, 40);
      rdy_mode = $urandom_range(0, 2);
      case (kind)
        0, 1, 2: send_frame(len, len, len - 1, -1, 0, 1);
        3:       send_frame(len, len, len - 1, $urandom_range(0, len - 1), 0, 1);
        4:       send_frame(($urandom_range(0, 1) == 1) ? 0 : 300, 1, 0, -1, 0, 0);
        default: send_frame(1, 1, ($urandom_range(0, 1) == 1) ? 0 : -1, -1, 0, 0);
      endcase
      wait_drain();
    end
    check("final_queue_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

endmodule
